// File: rtl/slot_allocator.sv
// rtl/slot_allocator.sv - free-bitmap slot allocator with multi-port offer, grant and release
module slot_allocator #(
    parameter int NUM_SLOTS = 32,
    parameter int NUM_ALLOC = 2,
    parameter int NUM_FREE  = 2,
    localparam int IDXW = $clog2(NUM_SLOTS),
    localparam int CW   = IDXW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      IN_flush,
    input  logic [NUM_ALLOC-1:0]      IN_allocReq,
    output logic [NUM_ALLOC*IDXW-1:0] OUT_allocIdx,
    output logic [NUM_ALLOC-1:0]      OUT_allocValid,
    input  logic [NUM_FREE-1:0]       IN_freeValid,
    input  logic [NUM_FREE*IDXW-1:0]  IN_freeIdx,
    output logic [CW-1:0]             OUT_freeCount,
    output logic                      OUT_full,
    output logic                      OUT_error
);

    logic [NUM_SLOTS-1:0] bitmap;
    logic [NUM_SLOTS-1:0] mask;
    logic [NUM_SLOTS-1:0] bm_next;
    logic [NUM_SLOTS-1:0] seen;
    logic [IDXW-1:0]      pick;
    logic [IDXW-1:0]      ridx;
    logic                 found;
    logic                 rel_err;
    logic [CW-1:0]        n_grant;
    logic [CW-1:0]        n_rel;
    logic [CW-1:0]        cnt_next;

    // Each port takes the lowest bit still set after earlier ports removed theirs.
    always_comb begin
        mask           = bitmap;
        OUT_allocValid = '0;
        OUT_allocIdx   = '0;
        found          = 1'b0;
        pick           = '0;
        for (int i = 0; i < NUM_ALLOC; i++) begin
            found = 1'b0;
            pick  = '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (!found && mask[s]) begin
                    found = 1'b1;
                    pick  = IDXW'(s);
                end
            end
            if (found) begin
                mask[pick] = 1'b0;
            end
            OUT_allocValid[i]             = found;
            OUT_allocIdx[i*IDXW +: IDXW]  = pick;
        end
    end

    always_comb begin
        bm_next = bitmap;
        seen    = '0;
        n_grant = '0;
        n_rel   = '0;
        rel_err = 1'b0;
        ridx    = '0;
        for (int i = 0; i < NUM_ALLOC; i++) begin
            if (IN_allocReq[i] && OUT_allocValid[i]) begin
                bm_next[OUT_allocIdx[i*IDXW +: IDXW]] = 1'b0;
                n_grant = n_grant + CW'(1);
            end
        end
        // A release is good only if in range, currently allocated, and not already released this cycle.
        for (int j = 0; j < NUM_FREE; j++) begin
            ridx = IN_freeIdx[j*IDXW +: IDXW];
            if (IN_freeValid[j]) begin
                if ({1'b0, ridx} >= CW'(NUM_SLOTS)) begin
                    rel_err = 1'b1;
                end else if (bitmap[ridx] || seen[ridx]) begin
                    rel_err = 1'b1;
                end else begin
                    seen[ridx]    = 1'b1;
                    bm_next[ridx] = 1'b1;
                    n_rel         = n_rel + CW'(1);
                end
            end
        end
        cnt_next = OUT_freeCount + n_rel - n_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap        <= '1;
            OUT_freeCount <= CW'(NUM_SLOTS);
            OUT_full      <= 1'b0;
            OUT_error     <= 1'b0;
        end else if (IN_flush) begin
            bitmap        <= '1;
            OUT_freeCount <= CW'(NUM_SLOTS);
            OUT_full      <= 1'b0;
            OUT_error     <= OUT_error | rel_err;
        end else begin
            bitmap        <= bm_next;
            OUT_freeCount <= cnt_next;
            OUT_full      <= (cnt_next == '0);
            OUT_error     <= OUT_error | rel_err;
        end
    end

endmodule

// File: tb/tb_slot_allocator.sv
// tb/tb_slot_allocator.sv - directed scoreboard bench for slot_allocator (32 and 24 slots)
module tb_slot_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [1:0] req;
    logic [9:0] aidx;
    logic [1:0] avalid;
    logic [1:0] fvalid;
    logic [9:0] fidx;
    logic [5:0] fcount;
    logic       full;
    logic       err;

    logic       flush24;
    logic [1:0] req24;
    logic [9:0] aidx24;
    logic [1:0] avalid24;
    logic [1:0] fvalid24;
    logic [9:0] fidx24;
    logic [5:0] fcount24;
    logic       full24;
    logic       err24;

    int nerr = 0;
    int nchk = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    slot_allocator #(.NUM_SLOTS(32), .NUM_ALLOC(2), .NUM_FREE(2)) dut (
        .clk(clk), .rst(rst), .IN_flush(flush), .IN_allocReq(req),
        .OUT_allocIdx(aidx), .OUT_allocValid(avalid),
        .IN_freeValid(fvalid), .IN_freeIdx(fidx),
        .OUT_freeCount(fcount), .OUT_full(full), .OUT_error(err)
    );

    slot_allocator #(.NUM_SLOTS(24), .NUM_ALLOC(2), .NUM_FREE(2)) dut24 (
        .clk(clk), .rst(rst), .IN_flush(flush24), .IN_allocReq(req24),
        .OUT_allocIdx(aidx24), .OUT_allocValid(avalid24),
        .IN_freeValid(fvalid24), .IN_freeIdx(fidx24),
        .OUT_freeCount(fcount24), .OUT_full(full24), .OUT_error(err24)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        int e;
        if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req = '0; fvalid = '0; fidx = '0;
        flush24 = 1'b0; req24 = '0; fvalid24 = '0; fidx24 = '0;
        tick(); tick();
        rst = 1'b0;
        #1;

        check("reset_count", fcount, 32);
        check("reset_full", full, 0);
        check("reset_error", err, 0);
        check("reset_valid", avalid, 2'b11);
        check("reset_idx0", aidx[4:0], 0);
        check("reset_idx1", aidx[9:5], 1);

        // Drain the whole pool two slots per cycle.
        req = 2'b11;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(2 * k);
            exp_q.push_back(2 * k + 1);
            check("drain_valid", avalid, 2'b11);
            check_pop("drain_idx0", aidx[4:0]);
            check_pop("drain_idx1", aidx[9:5]);
            tick();
        end
        req = 2'b00;
        check("drained_count", fcount, 0);
        check("drained_full", full, 1);
        check("drained_valid", avalid, 2'b00);

        // Release slot 7 while port 0 requests: no grant this cycle.
        fvalid = 2'b01; fidx = 10'd7; req = 2'b01;
        check("rel7_no_offer", avalid, 2'b00);
        tick();
        fvalid = 2'b00; req = 2'b00;
        check("rel7_valid", avalid, 2'b01);
        check("rel7_idx0", aidx[4:0], 7);
        check("rel7_count", fcount, 1);
        check("rel7_full", full, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush1_count", fcount, 32);

        // Take 0..3, then request only on port 1.
        req = 2'b11;
        tick(); tick();
        req = 2'b10;
        exp_q.push_back(5);
        check("port1_valid", avalid[1], 1);
        check_pop("port1_idx", aidx[9:5]);
        tick();
        req = 2'b00;
        check("port1_count", fcount, 27);
        check("port1_slot4_free", aidx[4:0], 4);
        check("port1_next_idx1", aidx[9:5], 6);

        // Release of already-free slot 9.
        fvalid = 2'b01; fidx = {5'd0, 5'd9};
        tick();
        check("err_free9", err, 1);
        check("err_free9_count", fcount, 27);
        // Both ports release slot 3: only one counts.
        fvalid = 2'b11; fidx = {5'd3, 5'd3};
        tick();
        fvalid = 2'b00;
        check("dup3_count", fcount, 28);
        check("dup3_err", err, 1);
        tick(); tick();
        check("err_sticky", err, 1);
        check("dup3_offer", aidx[4:0], 3);

        // Allocate up to ten taken slots, then flush with a grant and a release.
        req = 2'b11;
        tick(); tick(); tick();
        req = 2'b00;
        check("ten_taken_count", fcount, 22);
        flush = 1'b1; req = 2'b11; fvalid = 2'b01; fidx = {5'd0, 5'd0};
        check("flush_cycle_valid", avalid, 2'b11);
        check("flush_cycle_idx0", aidx[4:0], 10);
        tick();
        flush = 1'b0; req = 2'b00; fvalid = 2'b00;
        check("flush_count", fcount, 32);
        check("flush_idx0", aidx[4:0], 0);
        check("flush_idx1", aidx[9:5], 1);
        check("flush_valid", avalid, 2'b11);
        check("flush_full", full, 0);
        check("flush_keeps_err", err, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_clears_err", err, 0);
        check("rst_count", fcount, 32);

        // 24-slot pool: drain, verify no padded index appears.
        check("p24_reset_count", fcount24, 24);
        req24 = 2'b11;
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(2 * k);
            exp_q.push_back(2 * k + 1);
            check("p24_valid", avalid24, 2'b11);
            check_pop("p24_idx0", aidx24[4:0]);
            check_pop("p24_idx1", aidx24[9:5]);
            tick();
        end
        req24 = 2'b00;
        check("p24_full", full24, 1);
        check("p24_count", fcount24, 0);
        check("p24_valid_empty", avalid24, 2'b00);
        check("p24_idx_zero", aidx24, 0);

        fvalid24 = 2'b01; fidx24 = {5'd0, 5'd30};
        tick();
        check("p24_oor_err", err24, 1);
        check("p24_oor_count", fcount24, 0);
        fvalid24 = 2'b01; fidx24 = {5'd0, 5'd23};
        tick();
        fvalid24 = 2'b00;
        check("p24_rel23_count", fcount24, 1);
        check("p24_rel23_idx", aidx24[4:0], 23);
        check("p24_rel23_valid", avalid24, 2'b01);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
